// File: rtl/axi_lite_reg_slave_pkg.sv
// Shared types and helpers for the AXI-Lite control register slave.
package axi_lite_reg_slave_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        WR_IDLE,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_t;

    // Replace the bytes of old_val selected by strb with the matching bytes of new_val.
    function automatic logic [31:0] wstrb_merge(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) merged[8*i +: 8] = new_val[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi_lite_reg_slave_if.sv
// AXI4-Lite bus bundle between the core-side master and the register slave.
interface axi_lite_reg_slave_if #(
    parameter int ADDR_W = 32
) ();
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave fronting a bank of 32-bit control registers plus one read-only
// status word in the top slot.
//
// state    | meaning
// ---------+------------------------------------------------------------
// WR_IDLE  | collecting AW and W (either order); commit once both present
// WR_RESP  | write committed, BVALID held until BREADY
// RD_IDLE  | ARREADY high, waiting for a read address
// RD_DATA  | RDATA/RRESP registered, RVALID held until RREADY
module axi_lite_reg_slave
    import axi_lite_reg_slave_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                            aclk,
    input  logic                            areset_n,
    axi_lite_reg_slave_if.slave             bus,
    input  logic [31:0]                     i_status,
    output logic [32*(NUM_REGS-1)-1:0]      o_regs,
    output logic                            o_wr_pulse,
    output logic [IDX_W-1:0]                o_wr_idx
);

    localparam int STATUS_IDX = NUM_REGS - 1;

    // Out of range: any address bit above the index field set, or index past the bank.
    function automatic logic addr_bad(input logic [ADDR_W-1:0] addr);
        logic [IDX_W-1:0] idx;
        idx = addr[IDX_W+1:2];
        return (addr[ADDR_W-1:IDX_W+2] != '0) || (int'(idx) >= NUM_REGS);
    endfunction

    logic [31:0]       regs [NUM_REGS-1];

    wr_state_t         wr_state;
    logic              aw_held;
    logic              w_held;
    logic [ADDR_W-1:0] awaddr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              bvalid_q;
    resp_t             bresp_q;

    rd_state_t         rd_state;
    logic              rvalid_q;
    resp_t             rresp_q;
    logic [31:0]       rdata_q;

    logic              aw_hs;
    logic              w_hs;
    logic              wr_go;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_bad;
    logic [IDX_W-1:0]  ar_idx;
    logic              ar_bad;
    logic              unused_addr_lsbs;

    assign bus.awready = !aw_held && !bvalid_q;
    assign bus.wready  = !w_held && !bvalid_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.arready = (rd_state == RD_IDLE);
    assign bus.rvalid  = rvalid_q;
    assign bus.rresp   = rresp_q;
    assign bus.rdata   = rdata_q;

    assign aw_hs = bus.awvalid && bus.awready;
    assign w_hs  = bus.wvalid && bus.wready;

    // A half that handshakes this cycle is used directly so commit needs no extra cycle.
    assign wr_addr = aw_held ? awaddr_q : bus.awaddr;
    assign wr_data = w_held  ? wdata_q  : bus.wdata;
    assign wr_strb = w_held  ? wstrb_q  : bus.wstrb;
    assign wr_go   = (wr_state == WR_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
    assign wr_idx  = wr_addr[IDX_W+1:2];
    assign wr_bad  = addr_bad(wr_addr) || (int'(wr_idx) == STATUS_IDX);

    assign ar_idx  = bus.araddr[IDX_W+1:2];
    assign ar_bad  = addr_bad(bus.araddr);

    assign unused_addr_lsbs = ^{wr_addr[1:0], bus.araddr[1:0]};

    for (genvar k = 0; k < NUM_REGS - 1; k++) begin : g_out
        assign o_regs[32*k +: 32] = regs[k];
    end

    // Write FSM: hold AW/W halves, commit byte-merged data, then hold B until accepted.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wr_state   <= WR_IDLE;
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            o_wr_pulse <= 1'b0;
            o_wr_idx   <= '0;
            for (int k = 0; k < NUM_REGS - 1; k++) regs[k] <= '0;
        end else begin
            o_wr_pulse <= 1'b0;
            case (wr_state)
                WR_IDLE: begin
                    if (aw_hs) begin
                        aw_held  <= 1'b1;
                        awaddr_q <= bus.awaddr;
                    end
                    if (w_hs) begin
                        w_held  <= 1'b1;
                        wdata_q <= bus.wdata;
                        wstrb_q <= bus.wstrb;
                    end
                    if (wr_go) begin
                        aw_held  <= 1'b0;
                        w_held   <= 1'b0;
                        bvalid_q <= 1'b1;
                        wr_state <= WR_RESP;
                        if (wr_bad) begin
                            bresp_q <= RESP_SLVERR;
                        end else begin
                            bresp_q <= RESP_OKAY;
                            if (wr_strb != 4'b0000) begin
                                regs[wr_idx] <= wstrb_merge(regs[wr_idx], wr_data, wr_strb);
                                o_wr_pulse   <= 1'b1;
                                o_wr_idx     <= wr_idx;
                            end
                        end
                    end
                end
                WR_RESP: begin
                    if (bus.bready) begin
                        bvalid_q <= 1'b0;
                        wr_state <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    // Read FSM: capture data (or status snapshot) on AR handshake, hold R until accepted.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            rd_state <= RD_IDLE;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (bus.arvalid) begin
                        rvalid_q <= 1'b1;
                        rd_state <= RD_DATA;
                        if (ar_bad) begin
                            rresp_q <= RESP_SLVERR;
                            rdata_q <= '0;
                        end else if (int'(ar_idx) == STATUS_IDX) begin
                            rresp_q <= RESP_OKAY;
                            rdata_q <= i_status;
                        end else begin
                            rresp_q <= RESP_OKAY;
                            rdata_q <= regs[ar_idx];
                        end
                    end
                end
                RD_DATA: begin
                    if (bus.rready) begin
                        rvalid_q <= 1'b0;
                        rd_state <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave with B/R expectation queues and a register model.
module tb_axi_lite_reg_slave;

    localparam int ADDR_W   = 32;
    localparam int NUM_REGS = 8;
    localparam int IDX_W    = 3;

    logic                          aclk = 1'b0;
    logic                          areset_n = 1'b0;
    logic [31:0]                   i_status = '0;
    logic [32*(NUM_REGS-1)-1:0]    o_regs;
    logic                          o_wr_pulse;
    logic [IDX_W-1:0]              o_wr_idx;

    axi_lite_reg_slave_if #(.ADDR_W(ADDR_W)) bus ();

    axi_lite_reg_slave #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) dut (
        .aclk       (aclk),
        .areset_n   (areset_n),
        .bus        (bus),
        .i_status   (i_status),
        .o_regs     (o_regs),
        .o_wr_pulse (o_wr_pulse),
        .o_wr_idx   (o_wr_idx)
    );

    always #5 aclk = ~aclk;

    typedef struct { logic [1:0] resp; } b_exp_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; } r_exp_t;

    b_exp_t      b_q [$];
    r_exp_t      r_q [$];
    logic [31:0] model [NUM_REGS-1];
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic logic wr_err(input logic [31:0] a);
        return (a[31:5] != 27'd0) || (a[4:2] == 3'd7);
    endfunction

    function automatic logic rd_err(input logic [31:0] a);
        return (a[31:5] != 27'd0);
    endfunction

    function automatic logic [31:0] merge_ref(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        for (int k = 0; k < NUM_REGS - 1; k++)
            chk($sformatf("%s_reg%0d", tag, k), o_regs[32*k +: 32], model[k]);
    endtask

    // AW valid raised at cycle aw_start, W valid at cycle w_start; each dropped after its handshake.
    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_start, input int w_start);
        logic aw_pend, w_pend, aw_fire, w_fire, exp_pulse;
        logic [2:0] idx;
        aw_pend   = 1'b1;
        w_pend    = 1'b1;
        idx       = addr[4:2];
        exp_pulse = !wr_err(addr) && (strb != 4'b0000);
        b_q.push_back('{resp: wr_err(addr) ? 2'b10 : 2'b00});
        if (exp_pulse) model[idx] = merge_ref(model[idx], data, strb);
        for (int c = 0; c < 40 && (aw_pend || w_pend); c++) begin
            if (c == aw_start) begin bus.awvalid = 1'b1; bus.awaddr = addr; end
            if (c == w_start)  begin bus.wvalid = 1'b1; bus.wdata = data; bus.wstrb = strb; end
            aw_fire = bus.awvalid && bus.awready;
            w_fire  = bus.wvalid && bus.wready;
            @(negedge aclk);
            if (aw_fire) begin bus.awvalid = 1'b0; aw_pend = 1'b0; end
            if (w_fire)  begin bus.wvalid = 1'b0;  w_pend = 1'b0;  end
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        chk({tag, "_hs_done"}, 32'({aw_pend, w_pend}), 32'd0);
        chk({tag, "_bvalid_lat"}, 32'(bus.bvalid), 32'd1);
        chk({tag, "_pulse"}, 32'(o_wr_pulse), 32'(exp_pulse));
        if (exp_pulse) chk({tag, "_wr_idx"}, 32'(o_wr_idx), 32'(idx));
    endtask

    task automatic collect_b(input string tag, input int stall);
        int waited;
        b_exp_t e;
        waited = 0;
        while (!bus.bvalid && waited < 20) begin @(negedge aclk); waited++; end
        chk({tag, "_bvalid"}, 32'(bus.bvalid), 32'd1);
        if (b_q.size() == 0) begin
            n_tests++; n_fail++;
            $error("FAIL %s_bq: observed=empty expected=entry", tag);
        end else begin
            e = b_q.pop_front();
            bus.bready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                @(negedge aclk);
                chk({tag, "_bhold_v"}, 32'(bus.bvalid), 32'd1);
                chk({tag, "_bhold_resp"}, 32'(bus.bresp), 32'(e.resp));
                chk({tag, "_bhold_rdy"}, 32'({bus.awready, bus.wready}), 32'd0);
            end
            bus.bready = 1'b1;
            chk({tag, "_bresp"}, 32'(bus.bresp), 32'(e.resp));
        end
        @(negedge aclk);
        bus.bready = 1'b0;
        chk({tag, "_bclr"}, 32'(bus.bvalid), 32'd0);
    endtask

    task automatic issue_read(input logic [31:0] addr, input logic [31:0] status);
        r_exp_t e;
        e.resp = rd_err(addr) ? 2'b10 : 2'b00;
        e.data = rd_err(addr) ? 32'd0 : (addr[4:2] == 3'd7) ? status : model[addr[4:2]];
        r_q.push_back(e);
        i_status    = status;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
    endtask

    task automatic collect_r(input string tag, input int stall);
        int waited;
        r_exp_t e;
        waited = 0;
        while (!bus.rvalid && waited < 20) begin @(negedge aclk); waited++; end
        chk({tag, "_rvalid"}, 32'(bus.rvalid), 32'd1);
        if (r_q.size() == 0) begin
            n_tests++; n_fail++;
            $error("FAIL %s_rq: observed=empty expected=entry", tag);
        end else begin
            e = r_q.pop_front();
            bus.rready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                @(negedge aclk);
                chk({tag, "_rhold_v"}, 32'(bus.rvalid), 32'd1);
                chk({tag, "_rhold_data"}, bus.rdata, e.data);
                chk({tag, "_rhold_arrdy"}, 32'(bus.arready), 32'd0);
            end
            bus.rready = 1'b1;
            chk({tag, "_rdata"}, bus.rdata, e.data);
            chk({tag, "_rresp"}, 32'(bus.rresp), 32'(e.resp));
        end
        @(negedge aclk);
        bus.rready = 1'b0;
        chk({tag, "_rclr"}, 32'(bus.rvalid), 32'd0);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] status,
                           input int stall);
        int waited;
        issue_read(addr, status);
        waited = 0;
        while (!bus.arready && waited < 20) begin @(negedge aclk); waited++; end
        @(negedge aclk);
        bus.arvalid = 1'b0;
        i_status    = ~status;
        chk({tag, "_rvalid_lat"}, 32'(bus.rvalid), 32'd1);
        collect_r(tag, stall);
    endtask

    initial begin
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        for (int k = 0; k < NUM_REGS - 1; k++) model[k] = '0;

        repeat (2) @(negedge aclk);
        chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_resp", 32'({bus.bresp, bus.rresp}), 32'd0);
        chk("rst_pulse_idx", 32'({o_wr_pulse, o_wr_idx}), 32'd0);
        chk_regs("rst");
        areset_n = 1'b1;
        @(negedge aclk);
        chk("idle_ready", 32'({bus.awready, bus.wready, bus.arready}), 32'b111);

        // AW and W together
        do_write("t1", 32'h04, 32'hDEAD_BEEF, 4'hF, 0, 0);
        collect_b("t1", 0);
        chk_regs("t1");

        // W three cycles ahead of AW, partial strobes
        do_write("t2", 32'h08, 32'h1122_3344, 4'b0101, 3, 0);
        collect_b("t2", 0);
        chk_regs("t2");

        // AW ahead of W, then a single-byte overwrite
        do_write("t2b", 32'h0C, 32'hCAFE_F00D, 4'hF, 0, 2);
        collect_b("t2b", 0);
        do_write("t2c", 32'h0E, 32'h7700_0000, 4'b1000, 0, 0);
        collect_b("t2c", 0);
        chk_regs("t2c");

        // Status window
        do_read("t3r", 32'h1C, 32'hA5A5_0001, 0);
        do_write("t3w", 32'h1C, 32'hFFFF_FFFF, 4'hF, 0, 0);
        collect_b("t3w", 0);
        chk_regs("t3w");

        // Out of range
        do_read("t4r", 32'h40, 32'h1234_5678, 0);
        do_write("t4w", 32'h40, 32'hFFFF_FFFF, 4'hF, 0, 0);
        collect_b("t4w", 0);
        chk_regs("t4w");

        // Zero strobes
        do_write("strb0", 32'h04, 32'h0BAD_0BAD, 4'h0, 0, 0);
        collect_b("strb0", 0);
        chk_regs("strb0");

        do_read("rd1", 32'h04, 32'h0, 0);
        do_read("rd2", 32'h0B, 32'h0, 0);

        // Back-pressure on B and R
        do_write("t5w", 32'h14, 32'h0F0F_0F0F, 4'hF, 0, 0);
        collect_b("t5w", 5);
        do_read("t5r", 32'h14, 32'h0, 5);

        // Read and write of the same register in the same cycle
        issue_read(32'h04, 32'h0);
        do_write("rw", 32'h04, 32'h1234_5678, 4'hF, 0, 0);
        bus.arvalid = 1'b0;
        collect_b("rw", 0);
        collect_r("rw", 0);
        do_read("rw_after", 32'h04, 32'h0, 0);

        // Reset with AW held and RVALID pending
        bus.awvalid = 1'b1; bus.awaddr = 32'h08;
        @(negedge aclk);
        bus.awvalid = 1'b0;
        bus.arvalid = 1'b1; bus.araddr = 32'h04;
        @(negedge aclk);
        bus.arvalid = 1'b0;
        chk("t6_pre_awheld", 32'(bus.awready), 32'd0);
        chk("t6_pre_rvalid", 32'(bus.rvalid), 32'd1);
        #2 areset_n = 1'b0;
        #1;
        for (int k = 0; k < NUM_REGS - 1; k++) model[k] = '0;
        chk("t6_rvalid", 32'(bus.rvalid), 32'd0);
        chk("t6_bvalid", 32'(bus.bvalid), 32'd0);
        chk("t6_rdata", bus.rdata, 32'd0);
        chk("t6_ready", 32'({bus.awready, bus.wready, bus.arready}), 32'b111);
        chk_regs("t6");
        @(negedge aclk);
        areset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            chk("t6_no_stray", 32'({bus.bvalid, bus.rvalid}), 32'd0);
        end
        bus.wvalid = 1'b1; bus.wdata = 32'h5555_AAAA; bus.wstrb = 4'hF;
        @(negedge aclk);
        bus.wvalid = 1'b0;
        repeat (3) @(negedge aclk);
        chk("t6_w_only", 32'(bus.bvalid), 32'd0);
        b_q.push_back('{resp: 2'b00});
        model[2] = 32'h5555_AAAA;
        bus.awvalid = 1'b1; bus.awaddr = 32'h08;
        @(negedge aclk);
        bus.awvalid = 1'b0;
        chk("t6_post_bvalid", 32'(bus.bvalid), 32'd1);
        collect_b("t6_post", 0);
        chk_regs("t6_post");
        do_read("t6_rd1", 32'h04, 32'h0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
